// File: rtl/errmod_arbiter.sv
// errmod_arbiter
//   Shares one JPEG-LS error-modulo-reduction + error-mapping datapath
//   between two residual producers and forwards tagged results to the
//   Golomb coder.
//
//   Stage 1 (s1) holds the reduced residual, -2^(M-1) .. 2^(M-1)-1.
//   Stage 2 (s2) is the output register and holds the mapped MErrval.
//
// Ports
//   clk, rst_n             : clock (rising edge), async active-low reset
//   reg_valid/reg_err/     : requester 0, regular-mode coding path
//     reg_ready
//   run_valid/run_err/     : requester 1, run-interruption coding path
//     run_ready
//   out_valid/out_ready    : result handshake toward the Golomb coder
//   out_errmod             : reduced residual, signed
//   out_merr               : mapped value, unsigned
//   out_src                : 0 = regular, 1 = run
//   busy                   : either pipeline stage holds data
//
// Handshake rule (all three interfaces): a transfer happens on a rising
// edge where valid && ready are both high. ready is derived only from the
// valids and pipeline occupancy, never from the data, and at most one of
// reg_ready/run_ready is high in a cycle.
module errmod_arbiter #(
  parameter int residual_length    = 9,
  parameter int modresidual_length = 8,
  parameter int FIXED_PRIO         = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          reg_valid,
  input  logic [residual_length-1:0]    reg_err,
  output logic                          reg_ready,
  input  logic                          run_valid,
  input  logic [residual_length-1:0]    run_err,
  output logic                          run_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [modresidual_length-1:0] out_errmod,
  output logic [modresidual_length-1:0] out_merr,
  output logic                          out_src,
  output logic                          busy
);

  localparam int RL = residual_length;
  localparam int MW = modresidual_length;

  logic          s1_valid_q;
  logic          s1_src_q;
  logic [MW-1:0] s1_errmod_q;
  logic          s2_valid_q;
  logic          s2_src_q;
  logic [MW-1:0] s2_errmod_q;
  logic [MW-1:0] s2_merr_q;
  logic          last_grant_q;

  logic          adv1;
  logic          adv2;
  logic          grant;
  logic          accept;
  logic [MW-1:0] sel_errmod;
  logic [MW-1:0] s1_merr;

  // Bits above the modulo width never influence the reduced residual:
  // adding 2^M and then subtracting 2^M when e' >= 2^(M-1) is exactly
  // "keep the low M bits and read them as signed".
  logic unused_hi;
  assign unused_hi = ^{reg_err[RL-1:MW], run_err[RL-1:MW]};

  always_comb begin
    adv2 = !s2_valid_q || out_ready;
    adv1 = !s1_valid_q || adv2;

    // Contention: round-robin against the last winner, or run always wins.
    if (reg_valid && run_valid) begin
      grant = (FIXED_PRIO != 0) ? 1'b1 : !last_grant_q;
    end else begin
      grant = run_valid;
    end

    reg_ready  = adv1 && !grant && reg_valid;
    run_ready  = adv1 &&  grant && run_valid;
    accept     = reg_ready || run_ready;

    sel_errmod = grant ? run_err[MW-1:0] : reg_err[MW-1:0];

    // 2e for e >= 0 and -2e-1 = ~(2e) for e < 0, all modulo 2^M.
    s1_merr    = {s1_errmod_q[MW-2:0], 1'b0} ^ {MW{s1_errmod_q[MW-1]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_src_q     <= 1'b0;
      s1_errmod_q  <= '0;
      s2_valid_q   <= 1'b0;
      s2_src_q     <= 1'b0;
      s2_errmod_q  <= '0;
      s2_merr_q    <= '0;
      // Regular path wins the first contention after reset.
      last_grant_q <= 1'b1;
    end else begin
      if (adv1) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_errmod_q  <= sel_errmod;
          s1_src_q     <= grant;
          last_grant_q <= grant;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_errmod_q <= s1_errmod_q;
          s2_merr_q   <= s1_merr;
          s2_src_q    <= s1_src_q;
        end
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_errmod = s2_errmod_q;
  assign out_merr   = s2_merr_q;
  assign out_src    = s2_src_q;
  assign busy       = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_errmod_arbiter.sv
module tb_errmod_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // round-robin instance
  logic       reg_valid, run_valid, out_ready;
  logic [8:0] reg_err, run_err;
  logic       reg_ready, run_ready, out_valid, out_src, busy;
  logic [7:0] out_errmod, out_merr;

  // fixed-priority instance
  logic       f_reg_valid, f_run_valid, f_out_ready;
  logic [8:0] f_reg_err, f_run_err;
  logic       f_reg_ready, f_run_ready, f_out_valid, f_out_src, f_busy;
  logic [7:0] f_out_errmod, f_out_merr;

  errmod_arbiter #(.residual_length(9), .modresidual_length(8), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_valid(reg_valid), .reg_err(reg_err), .reg_ready(reg_ready),
    .run_valid(run_valid), .run_err(run_err), .run_ready(run_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_errmod(out_errmod), .out_merr(out_merr), .out_src(out_src),
    .busy(busy)
  );

  errmod_arbiter #(.residual_length(9), .modresidual_length(8), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .reg_valid(f_reg_valid), .reg_err(f_reg_err), .reg_ready(f_reg_ready),
    .run_valid(f_run_valid), .run_err(f_run_err), .run_ready(f_run_ready),
    .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_errmod(f_out_errmod), .out_merr(f_out_merr), .out_src(f_out_src),
    .busy(f_busy)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Arithmetic reference for the reduction and the mapping.
  function automatic int ref_mod(input logic [8:0] err);
    int e;
    e = int'($signed(err));
    if (e < 0) e += 256;
    if (e >= 128) e -= 256;
    return e;
  endfunction

  function automatic int ref_merr(input int e);
    return (e >= 0) ? 2 * e : -2 * e - 1;
  endfunction

  // In-flight items in acceptance order; the pipeline holds at most two.
  // An item becomes visible at the output once at least one edge has
  // passed since the edge that accepted it.
  typedef struct {
    logic [8:0] err;
    logic       src;
    int         acc;
  } item_t;

  item_t mq[$];
  int    edge_cnt = 0;
  logic  m_last   = 1'b1;
  logic  m_rr, m_rn, m_ov;

  function automatic logic m_out_valid();
    if (mq.size() == 0) return 1'b0;
    return mq[0].acc != edge_cnt;
  endfunction

  function automatic logic m_grant();
    if (reg_valid && run_valid) return !m_last;
    return run_valid;
  endfunction

  function automatic logic m_room();
    return (mq.size() < 2) || (m_out_valid() && out_ready);
  endfunction

  // model update
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_last   = 1'b1;
        edge_cnt = 0;
      end else begin
        m_ov = m_out_valid();
        m_rr = m_room() && reg_valid && !m_grant();
        m_rn = m_room() && run_valid && m_grant();
        if (m_ov && out_ready) void'(mq.pop_front());
        edge_cnt++;
        if (m_rr) begin
          mq.push_back('{err: reg_err, src: 1'b0, acc: edge_cnt});
          m_last = 1'b0;
        end
        if (m_rn) begin
          mq.push_back('{err: run_err, src: 1'b1, acc: edge_cnt});
          m_last = 1'b1;
        end
      end
    end
  end

  // compare process: every cycle out of reset, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("reg_ready", 32'(reg_ready), 32'(m_room() && reg_valid && !m_grant()));
        chk("run_ready", 32'(run_ready), 32'(m_room() && run_valid && m_grant()));
        chk("out_valid", 32'(out_valid), 32'(m_out_valid()));
        chk("busy", 32'(busy), 32'(mq.size() > 0));
        if (m_out_valid()) begin
          chk("out_errmod", 32'(out_errmod), 32'(ref_mod(mq[0].err) & 255));
          chk("out_merr", 32'(out_merr), 32'(ref_merr(ref_mod(mq[0].err))));
          chk("out_src", 32'(out_src), 32'(mq[0].src));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_one(input logic src, input logic [8:0] err,
                          input logic [7:0] x_errmod, input logic [7:0] x_merr,
                          input string tag);
    @(posedge clk); #1;
    out_ready = 1'b1;
    if (src) begin run_valid = 1'b1; run_err = err; end
    else     begin reg_valid = 1'b1; reg_err = err; end
    @(negedge clk);
    chk({tag, "_ready"}, 32'(src ? run_ready : reg_ready), 32'd1);
    @(posedge clk); #1;
    reg_valid = 1'b0;
    run_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat_s1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_errmod"}, 32'(out_errmod), 32'(x_errmod));
    chk({tag, "_merr"}, 32'(out_merr), 32'(x_merr));
    chk({tag, "_src"}, 32'(out_src), 32'(src));
  endtask

  // ---------------- main sequence ----------------
  logic       acc_r, acc_n;
  logic [8:0] items[3];
  int         idx, pops;

  initial begin
    rst_n = 1'b1;
    reg_valid = 1'b0; run_valid = 1'b0; out_ready = 1'b0;
    reg_err = '0; run_err = '0;
    f_reg_valid = 1'b0; f_run_valid = 1'b0; f_out_ready = 1'b1;
    f_reg_err = '0; f_run_err = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errmod", 32'(out_errmod), 32'd0);
    chk("rst_merr", 32'(out_merr), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_fp_busy", 32'(f_busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;

    // single regular residual, then boundary residuals through the run path
    send_one(1'b0, 9'h1FF, 8'hFF, 8'd1,   "t1_neg1");
    send_one(1'b1, 9'h0C8, 8'hC8, 8'd111, "t2_p200");
    send_one(1'b1, 9'h138, 8'h38, 8'd112, "t2_m200");
    send_one(1'b1, 9'h080, 8'h80, 8'd255, "t2_080");
    send_one(1'b1, 9'h07F, 8'h7F, 8'd254, "t2_07f");
    send_one(1'b1, 9'h180, 8'h80, 8'd255, "t2_180");

    // round-robin under continuous contention
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      reg_valid = (i < 4);
      run_valid = (i < 4);
      reg_err   = 9'h010 + 9'(i);
      run_err   = 9'h1A0 + 9'(i);
      @(negedge clk);
      if (i < 4) begin
        chk("rr_run_ready", 32'(run_ready), 32'(i % 2));
        chk("rr_reg_ready", 32'(reg_ready), 32'((i + 1) % 2));
      end
      if (i >= 2) begin
        chk("rr_out_valid", 32'(out_valid), 32'd1);
        chk("rr_out_src", 32'(out_src), 32'((i - 2) % 2));
      end
    end

    // backpressure: three regular residuals against a stalled sink
    items[0] = 9'h005; items[1] = 9'h1F0; items[2] = 9'h040;
    exp_q.push_back(8'h05); exp_q.push_back(8'hF0); exp_q.push_back(8'h40);
    @(posedge clk); #1;
    out_ready = 1'b0;
    reg_valid = 1'b1; run_valid = 1'b0;
    reg_err = items[0];
    idx = 0; pops = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      acc_r = reg_valid && reg_ready;
      if (c >= 2 && c < 8) begin
        chk("stall_reg_ready", 32'(reg_ready), 32'd0);
        chk("stall_run_ready", 32'(run_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_errmod", 32'(out_errmod), 32'h05);
        chk("stall_merr", 32'(out_merr), 32'd10);
      end
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() > 0) chk("drain_order", 32'(out_errmod), 32'(exp_q.pop_front()));
      end
      @(posedge clk); #1;
      if (acc_r) begin
        idx++;
        if (idx < 3) reg_err = items[idx];
        else         reg_valid = 1'b0;
      end
      if (c == 7) out_ready = 1'b1;
    end
    chk("drain_count", 32'(pops), 32'd3);
    chk("drain_left", 32'(exp_q.size()), 32'd0);

    // fixed priority: run always wins while it is valid
    @(posedge clk); #1;
    f_out_ready = 1'b1;
    f_reg_valid = 1'b1; f_run_valid = 1'b1;
    f_reg_err = 9'h033; f_run_err = 9'h011;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fp_run_ready", 32'(f_run_ready), 32'd1);
      chk("fp_reg_ready", 32'(f_reg_ready), 32'd0);
      if (i >= 2) chk("fp_out_src", 32'(f_out_src), 32'd1);
      @(posedge clk); #1;
      f_run_err = 9'($urandom_range(0, 511));
    end
    f_run_valid = 1'b0;
    @(negedge clk);
    chk("fp_reg_after_drop", 32'(f_reg_ready), 32'd1);
    @(posedge clk); #1;
    f_reg_valid = 1'b0;

    // randomized traffic; producers hold valid and data until accepted
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc_r = reg_valid && reg_ready;
      acc_n = run_valid && run_ready;
      @(posedge clk); #1;
      if (!reg_valid || acc_r) begin
        reg_valid = ($urandom_range(0, 99) < 60);
        reg_err   = 9'($urandom_range(0, 511));
      end
      if (!run_valid || acc_n) begin
        run_valid = ($urandom_range(0, 99) < 60);
        run_err   = 9'($urandom_range(0, 511));
      end
      out_ready = ($urandom_range(0, 99) < 70);
    end

    // asynchronous reset with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0; reg_valid = 1'b1; run_valid = 1'b0;
    reg_err = 9'($urandom_range(0, 511));
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_errmod", 32'(out_errmod), 32'd0);
    chk("async_rst_merr", 32'(out_merr), 32'd0);
    chk("async_rst_src", 32'(out_src), 32'd0);
    reg_valid = 1'b1; run_valid = 1'b1; out_ready = 1'b1;
    reg_err = 9'h0AA; run_err = 9'h155;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_reg_first", 32'(reg_ready), 32'd1);
    chk("post_rst_run_wait", 32'(run_ready), 32'd0);
    @(posedge clk); #1;
    reg_valid = 1'b0; run_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
